serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around a single full-adder cell. It accepts two operands and a carry-in over a valid/ready handshake. It then feeds the cell one bit pair per clock, LSB first, with the cell's carry-out registered back to its carry-in. It presents the WIDTH-bit sum, carry-out and signed overflow on a valid/ready output handshake. It is the sequential datapath stage that consumes the full-adder cell and produces multi-bit results for downstream ALU work.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_adder_if.sv | 28 ++
 rtl/structuralFullAdder.sv | 21 ++
 rtl/serial_adder.sv | 108 ++++++++++
 tb/tb_serial_adder.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// a ceiling-log2 helper used to size the bit counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, carryin, out_ready,
    input  in_ready, out_valid, sum, carryout, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, carryin, out_ready,
    output in_ready, out_valid, sum, carryout, overflow, busy
  );

endinterface

// File: rtl/structuralFullAdder.sv
// Gate-level one-bit full adder; a behavioural adder with the same port
// order can be swapped in for comparison runs.
module structuralFullAdder (
  output logic sum,
  output logic carryout,
  input  logic a,
  input  logic b,
  input  logic carryin
);

  logic half_sum;
  logic gen_ab;
  logic prop_c;

  xor g_x1 (half_sum, a, b);
  xor g_x2 (sum, half_sum, carryin);
  and g_a1 (gen_ab, a, b);
  and g_a2 (prop_c, half_sum, carryin);
  or  g_o1 (carryout, gen_ab, prop_c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell consumes an operand bit
// pair per clock, LSB first, with its carry recirculated through a register.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  serial_adder_if.slave bus
);

  localparam int CNT_W = clog2(WIDTH);

  state_t             state_reg;
  state_t             state_next;
  logic [WIDTH-1:0]   a_sh_reg;
  logic [WIDTH-1:0]   b_sh_reg;
  logic [WIDTH-1:0]   acc_reg;
  logic               c_reg;
  logic               cmsb_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               carryout_reg;
  logic               overflow_reg;

  logic               cell_s;
  logic               cell_co;
  logic [WIDTH-1:0]   acc_next;
  logic               last_bit;
  logic               msb_carry_bit;

  structuralFullAdder u_cell (
    .sum      (cell_s),
    .carryout (cell_co),
    .a        (a_sh_reg[0]),
    .b        (b_sh_reg[0]),
    .carryin  (c_reg)
  );

  assign acc_next      = {cell_s, acc_reg[WIDTH-1:1]};
  assign last_bit      = (cnt_reg == CNT_W'(WIDTH - 1));
  assign msb_carry_bit = (cnt_reg == CNT_W'(WIDTH - 2));

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.in_valid)  state_next = S_RUN;
      S_RUN:   if (last_bit)      state_next = S_DONE;
      S_DONE:  if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_reg     <= '0;
      b_sh_reg     <= '0;
      acc_reg      <= '0;
      c_reg        <= 1'b0;
      cmsb_reg     <= 1'b0;
      cnt_reg      <= '0;
      sum_reg      <= '0;
      carryout_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_sh_reg <= bus.a;
            b_sh_reg <= bus.b;
            c_reg    <= bus.carryin;
            cnt_reg  <= '0;
            acc_reg  <= '0;
          end
        end
        S_RUN: begin
          a_sh_reg <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg <= {1'b0, b_sh_reg[WIDTH-1:1]};
          acc_reg  <= acc_next;
          c_reg    <= cell_co;
          cnt_reg  <= cnt_reg + 1'b1;
          // Carry produced by bit WIDTH-2 is the carry into the sign bit.
          if (msb_carry_bit) cmsb_reg <= cell_co;
          if (last_bit) begin
            sum_reg      <= acc_next;
            carryout_reg <= cell_co;
            overflow_reg <= cmsb_reg ^ cell_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.out_valid = (state_reg == S_DONE);
  assign bus.busy      = (state_reg == S_RUN);
  assign bus.sum       = sum_reg;
  assign bus.carryout  = carryout_reg;
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one operation and waits (bounded) for out_valid; leaves DONE pending.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                        output int lat, output logic [7:0] s, output logic co,
                        output logic ov);
    @(negedge clk);
    bus.a        = av;
    bus.b        = bv;
    bus.carryin  = ci;
    bus.in_valid = 1'b1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready: got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_accept: got %b want 1", bus.busy);
    end
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid === 1'b1) break;
    end
    s  = bus.sum;
    co = bus.carryout;
    ov = bus.overflow;
    $display("op a=%h b=%h ci=%b -> sum=%h co=%b ovf=%b lat=%0d", av, bv, ci, s, co, ov, lat);
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release: got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.carryin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.sum !== 8'h00 || bus.carryout !== 1'b0 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_result: got sum=%h co=%b ovf=%b want 00/0/0", bus.sum, bus.carryout, bus.overflow);
    end
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_flags: got out_valid=%b busy=%b in_ready=%b want 0/0/1",
               bus.out_valid, bus.busy, bus.in_ready);
    end
    $display("reset done");
  endtask

  task automatic test_arith();
    logic [7:0] va  [7] = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'hA5, 8'h3C, 8'h80};
    logic [7:0] vb  [7] = '{8'h00, 8'h01, 8'h01, 8'h80, 8'h5A, 8'hC3, 8'hFF};
    logic       vci [7] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
    logic [7:0] es  [7] = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'hFF, 8'h7F};
    logic       eco [7] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    logic       eov [7] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
    int         lat;
    logic [7:0] s;
    logic       co;
    logic       ov;
    for (int k = 0; k < 7; k++) begin
      run_op(va[k], vb[k], vci[k], lat, s, co, ov);
      total++;
      if (lat !== 8) begin
        bad++;
        $display("FAIL latency[%0d]: got %0d want 8", k, lat);
      end
      total++;
      if (s !== es[k] || co !== eco[k] || ov !== eov[k]) begin
        bad++;
        $display("FAIL result[%0d]: got sum=%h co=%b ovf=%b want %h/%b/%b",
                 k, s, co, ov, es[k], eco[k], eov[k]);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int         lat;
    logic [7:0] s;
    logic       co;
    logic       ov;
    run_op(8'h12, 8'h34, 1'b0, lat, s, co, ov);
    total++;
    if (s !== 8'h46 || co !== 1'b0 || ov !== 1'b0) begin
      bad++;
      $display("FAIL bp_result: got sum=%h co=%b ovf=%b want 46/0/0", s, co, ov);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 8'hFF;
      bus.b        = 8'hFF;
      bus.carryin  = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== 8'h46 ||
          bus.carryout !== 1'b0 || bus.overflow !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b sum=%h co=%b ovf=%b want 1/0/46/0/0",
                 i, bus.out_valid, bus.in_ready, bus.sum, bus.carryout, bus.overflow);
      end
    end
    bus.in_valid = 1'b0;
    release_result();
    total++;
    if (bus.sum !== 8'h46) begin
      bad++;
      $display("FAIL bp_retain: got sum=%h want 46", bus.sum);
    end
    run_op(8'h01, 8'h02, 1'b0, lat, s, co, ov);
    total++;
    if (s !== 8'h03 || lat !== 8) begin
      bad++;
      $display("FAIL bp_next: got sum=%h lat=%0d want 03/8", s, lat);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int         lat;
    logic [7:0] s;
    logic       co;
    logic       ov;
    @(negedge clk);
    bus.a        = 8'hFF;
    bus.b        = 8'h01;
    bus.carryin  = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.sum !== 8'h00 ||
        bus.carryout !== 1'b0 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: got busy=%b out_valid=%b sum=%h co=%b ovf=%b want 0/0/00/0/0",
               bus.busy, bus.out_valid, bus.sum, bus.carryout, bus.overflow);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrun_ready: got %b want 1", bus.in_ready);
    end
    run_op(8'h03, 8'h04, 1'b0, lat, s, co, ov);
    total++;
    if (s !== 8'h07 || co !== 1'b0 || ov !== 1'b0 || lat !== 8) begin
      bad++;
      $display("FAIL midrun_next: got sum=%h co=%b ovf=%b lat=%0d want 07/0/0/8", s, co, ov, lat);
    end
    release_result();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
